uart_rx_param: RTL

- Parametrised successor to the team's fixed 7-bit Hamming UART receiver.
- Receives one asynchronous serial frame: start bit, DATA_BITS data bits LSB first, optional parity bit, then STOP_BITS stop bits.
- Adds an input synchroniser, 3-sample majority voting, parity and framing checks, and a valid/ready output handshake with overrun detection.
- Sits between the pad-level rx line and the Hamming(7,4) decoder or any other frame consumer.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_sampler.sv | 68 ++++++
 rtl/uart_rx_param.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the parametrised UART receiver:
//                FSM state encoding, parity mode constants and a helper
//                that sizes the oversample tick counter.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
package uart_pkg;

    // FSM state encoding (also exported on state_out for debug)
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_START      = 3'd1;
    localparam logic [2:0] ST_DATA       = 3'd2;
    localparam logic [2:0] ST_PARITY     = 3'd3;
    localparam logic [2:0] ST_STOP       = 3'd4;
    localparam logic [2:0] ST_BREAK_WAIT = 3'd5;

    // Parity modes
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Width of a counter that must hold 0 .. oversample-1
    function automatic int cnt_width(input int oversample);
        return (oversample > 2) ? $clog2(oversample) : 1;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sampler
//  Description : Two-flop synchroniser for the asynchronous rx pad, optional
//                polarity inversion, and a 3-tap majority vote over the last
//                three ena ticks.
//  Ports       : clk, rst   - clock, async active-high reset
//                ena        - oversample tick (gates only the vote history)
//                rx         - raw serial line
//                s_rx       - synchronised (and optionally inverted) line
//                vote       - majority of s_rx over the current and two
//                             previous ena ticks
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sampler #(
    parameter int RX_INVERT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic rx,
    output logic s_rx,
    output logic vote
);

    // Synchroniser flops reset to the physical idle level so that an
    // inverted line does not look like a start bit straight out of reset.
    localparam logic c_pad_idle = (RX_INVERT != 0) ? 1'b0 : 1'b1;

    logic       r_sync1;
    logic       r_sync2;
    logic [1:0] r_hist;
    logic       w_s_rx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= c_pad_idle;
            r_sync2 <= c_pad_idle;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (RX_INVERT != 0) begin : g_invert
            assign w_s_rx = ~r_sync2;
        end else begin : g_direct
            assign w_s_rx = r_sync2;
        end
    endgenerate

    // History of the two previous ena-tick samples; together with the live
    // sample they form the three voting taps. When the FSM evaluates the
    // vote at tick mid+1, r_hist holds ticks mid-1 and mid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= 2'b11;
        end else if (ena) begin
            r_hist <= {r_hist[0], w_s_rx};
        end
    end

    assign s_rx = w_s_rx;
    assign vote = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_s_rx) | (r_hist[0] & w_s_rx);

endmodule : uart_rx_sampler
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_param
//  Description : Parametrised UART receiver. Start bit, DATA_BITS data bits
//                LSB first, optional parity, STOP_BITS stop bits. Majority
//                voted sampling, parity/framing checks, valid/ready output
//                with sticky overrun.
//  Ports       : clk, rst          - clock, async active-high reset
//                ena               - oversample tick
//                rx                - serial line
//                data_out          - received word (bit 0 first on wire)
//                valid_out         - word available
//                ready_in          - consumer accepts word
//                parity_err        - parity mismatch for held word
//                frame_err         - stop bit sampled low for held word
//                overrun           - sticky: frame lost while output full
//                state_out         - FSM state for debug
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module uart_rx_param #(
    parameter int DATA_BITS  = 7,
    parameter int OVERSAMPLE = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int RX_INVERT  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic [2:0]           state_out
);

    import uart_pkg::*;

    localparam int             c_cw        = cnt_width(OVERSAMPLE);
    localparam logic [c_cw-1:0] c_vote_tick = c_cw'(OVERSAMPLE / 2 + 1);
    localparam logic [c_cw-1:0] c_last_tick = c_cw'(OVERSAMPLE - 1);
    localparam logic [3:0]     c_last_data = 4'(DATA_BITS - 1);
    localparam logic [3:0]     c_last_stop = 4'(STOP_BITS - 1);

    logic                 w_s_rx;
    logic                 w_vote;

    logic [2:0]           r_state;
    logic [c_cw-1:0]      r_cnt;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_perr_pend;
    logic                 r_ferr_pend;

    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_overrun;

    logic                 w_vote_tick;
    logic                 w_last_tick;
    logic                 w_par_exp;
    logic                 w_ferr_now;
    logic                 w_complete;

    uart_rx_sampler #(
        .RX_INVERT (RX_INVERT)
    ) u_sampler (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .rx   (rx),
        .s_rx (w_s_rx),
        .vote (w_vote)
    );

    assign w_vote_tick = (r_cnt == c_vote_tick);
    assign w_last_tick = (r_cnt == c_last_tick);
    assign w_par_exp   = (PARITY == PAR_ODD) ? ~(^r_shreg) : (^r_shreg);

    // The last stop bit's own vote is folded in so the completing word sees it
    assign w_ferr_now  = r_ferr_pend | ~w_vote;
    assign w_complete  = ena && (r_state == ST_STOP) && w_vote_tick &&
                         (r_bit_cnt == c_last_stop);

    // ------------------------------------------------------------------
    // Receive FSM: advances only on ena ticks
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_perr_pend <= 1'b0;
            r_ferr_pend <= 1'b0;
        end else if (ena) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_s_rx) begin
                        r_state     <= ST_START;
                        r_cnt       <= '0;
                        r_perr_pend <= 1'b0;
                        r_ferr_pend <= 1'b0;
                    end
                end

                ST_START: begin
                    r_cnt <= w_last_tick ? '0 : r_cnt + 1'b1;
                    if (w_vote_tick && w_vote) begin
                        // Start bit did not hold low: treat as a glitch
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (w_last_tick) begin
                        r_state   <= ST_DATA;
                        r_bit_cnt <= '0;
                    end
                end

                ST_DATA: begin
                    r_cnt <= w_last_tick ? '0 : r_cnt + 1'b1;
                    if (w_vote_tick) begin
                        r_shreg <= {w_vote, r_shreg[DATA_BITS-1:1]};
                    end
                    if (w_last_tick) begin
                        if (r_bit_cnt == c_last_data) begin
                            r_state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                            r_bit_cnt <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end

                ST_PARITY: begin
                    r_cnt <= w_last_tick ? '0 : r_cnt + 1'b1;
                    if (w_vote_tick && (w_vote != w_par_exp)) begin
                        r_perr_pend <= 1'b1;
                    end
                    if (w_last_tick) begin
                        r_state   <= ST_STOP;
                        r_bit_cnt <= '0;
                    end
                end

                ST_STOP: begin
                    r_cnt <= w_last_tick ? '0 : r_cnt + 1'b1;
                    if (w_vote_tick && !w_vote) begin
                        r_ferr_pend <= 1'b1;
                    end
                    if (w_vote_tick && (r_bit_cnt == c_last_stop)) begin
                        // Finish mid-bit so a back-to-back start edge is seen
                        r_state <= w_ferr_now ? ST_BREAK_WAIT : ST_IDLE;
                        r_cnt   <= '0;
                    end else if (w_last_tick) begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end

                ST_BREAK_WAIT: begin
                    // A held-low line must return high before a new frame
                    if (w_s_rx) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output register and handshake: runs every clk, not ena-gated
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_complete) begin
                if (!r_valid || ready_in) begin
                    r_data  <= r_shreg;
                    r_perr  <= r_perr_pend;
                    r_ferr  <= w_ferr_now;
                    r_valid <= 1'b1;
                end else begin
                    // Held word is kept; the new frame is dropped
                    r_overrun <= 1'b1;
                end
            end else if (ready_in) begin
                r_valid <= 1'b0;
            end

            if (r_valid && ready_in) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign data_out   = r_data;
    assign valid_out  = r_valid;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign overrun    = r_overrun;
    assign state_out  = r_state;

endmodule : uart_rx_param
`default_nettype wire
